// File: rtl/serial_slice_alu.sv
// serial_slice_alu: multi-cycle ALU that processes a WIDTH-bit operation as a
// chain of SLICE_W-bit slices, LSB slice first, with the carry registered
// between cycles. Every function takes N = WIDTH/SLICE_W cycles.
//
// Function select s:
//   000 f=0 | 001 B+~A+cn | 010 A+~B+cn | 011 A+B+cn
//   100 A^B | 101 A|B     | 110 A&B     | 111 all ones
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   operand handshake (a, b, s, cn latched on accept)
//   out_valid/out_ready result handshake; result held until out_ready
//   f, cout             result and carry out of the MSB (0 for logic codes)
//   zero, neg, ovf      result flags (0 unless the flags build is selected)
//
// Build option: define SERIAL_ALU_FLAGS_EN to compute zero/neg/ovf on the
// final slice; without it the flag outputs are tied to 0.
module serial_slice_alu #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SLICE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       s,
  input  logic             cn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int unsigned N     = WIDTH / SLICE_W;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  generate
    if ((SLICE_W == 0) || (WIDTH % SLICE_W != 0) || (WIDTH < SLICE_W)) begin : g_bad_cfg
      $error("serial_slice_alu: WIDTH must be a non-zero multiple of SLICE_W");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, f_q, f_d;
  logic [2:0]         s_q, s_d;
  logic               carry_q, carry_d, cout_q, cout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               zero_d, neg_d, ovf_d;

  logic               accept;
  logic               arith;
  logic [SLICE_W-1:0] a_sl, b_sl, x_sl, y_sl, res_sl;
  logic [SLICE_W:0]   sum;

  always_comb begin
    in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    accept   = in_valid && in_ready;

    a_sl  = a_q[cnt_q*SLICE_W +: SLICE_W];
    b_sl  = b_q[cnt_q*SLICE_W +: SLICE_W];
    arith = (s_q == 3'b001) || (s_q == 3'b010) || (s_q == 3'b011);
    x_sl  = (s_q == 3'b001) ? ~a_sl : a_sl;
    y_sl  = (s_q == 3'b010) ? ~b_sl : b_sl;
    sum   = {1'b0, x_sl} + {1'b0, y_sl} + {{SLICE_W{1'b0}}, carry_q};

    case (s_q)
      3'b000:                 res_sl = '0;
      3'b001, 3'b010, 3'b011: res_sl = sum[SLICE_W-1:0];
      3'b100:                 res_sl = a_sl ^ b_sl;
      3'b101:                 res_sl = a_sl | b_sl;
      3'b110:                 res_sl = a_sl & b_sl;
      default:                res_sl = '1;
    endcase

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    f_d     = f_q;
    cout_d  = cout_q;
    zero_d  = 1'b0;
    neg_d   = 1'b0;
    ovf_d   = 1'b0;

    case (state_q)
      RUN: begin
        f_d[cnt_q*SLICE_W +: SLICE_W] = res_sl;
        carry_d = arith && sum[SLICE_W];
        if (cnt_q == LAST) begin
          // Counter stays at LAST rather than incrementing, so N=1 needs no wrap.
          state_d = DONE;
          cout_d  = arith && sum[SLICE_W];
          zero_d  = (f_d == '0);
          neg_d   = f_d[WIDTH-1];
          // Carry into the MSB is recovered from the MSB sum bit of the final slice.
          ovf_d   = arith && ((x_sl[SLICE_W-1] ^ y_sl[SLICE_W-1] ^ sum[SLICE_W-1]) ^ sum[SLICE_W]);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: ;
    endcase

    if (accept) begin
      state_d = RUN;
      a_d     = a;
      b_d     = b;
      s_d     = s;
      carry_d = cn;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      f_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      cout_q  <= cout_d;
    end
  end

`ifdef SERIAL_ALU_FLAGS_EN
  logic zero_q, neg_q, ovf_q;

  // Flags only change on the final slice, so they stay stable through DONE and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if ((state_q == RUN) && (cnt_q == LAST)) begin
      zero_q <= zero_d;
      neg_q  <= neg_d;
      ovf_q  <= ovf_d;
    end
  end

  assign zero = zero_q;
  assign neg  = neg_q;
  assign ovf  = ovf_q;
`else
  logic unused_flags;
  assign unused_flags = zero_d ^ neg_d ^ ovf_d;
  assign zero = 1'b0;
  assign neg  = 1'b0;
  assign ovf  = 1'b0;
`endif

  assign out_valid = (state_q == DONE);
  assign f         = f_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_slice_alu.sv
module tb_serial_slice_alu;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 16-bit / 4-bit-slice instance
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, f;
  logic [2:0]  s;
  logic        cn, cout, zero, neg, ovf;

  // 4-bit / 4-bit-slice instance (single-cycle RUN)
  logic        w4_in_valid, w4_in_ready, w4_out_valid, w4_out_ready;
  logic [3:0]  w4_a, w4_b, w4_f;
  logic [2:0]  w4_s;
  logic        w4_cn, w4_cout, w4_zero, w4_neg, w4_ovf;

  serial_slice_alu #(.WIDTH(16), .SLICE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .s(s), .cn(cn), .out_valid(out_valid), .out_ready(out_ready),
    .f(f), .cout(cout), .zero(zero), .neg(neg), .ovf(ovf)
  );

  serial_slice_alu #(.WIDTH(4), .SLICE_W(4)) dut_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(w4_in_valid), .in_ready(w4_in_ready),
    .a(w4_a), .b(w4_b), .s(w4_s), .cn(w4_cn), .out_valid(w4_out_valid),
    .out_ready(w4_out_ready), .f(w4_f), .cout(w4_cout), .zero(w4_zero),
    .neg(w4_neg), .ovf(w4_ovf)
  );

`ifdef SERIAL_ALU_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: whole-word arithmetic on w-bit operands; overflow from operand/result signs.
  function automatic void model(input int w, input logic [15:0] ai, input logic [15:0] bi,
                                input logic [2:0] si, input logic ci,
                                output logic [15:0] fo, output logic co, output logic ov,
                                output logic zo, output logic no);
    longint unsigned mask, x, y, r;
    bit ar;
    mask = (64'd1 << w) - 1;
    x = ai; y = bi; ar = 0; co = 0; ov = 0; r = 0;
    case (si)
      3'd0: r = 0;
      3'd1: begin x = ~x & mask; ar = 1; end
      3'd2: begin y = ~y & mask; ar = 1; end
      3'd3: ar = 1;
      3'd4: r = x ^ y;
      3'd5: r = x | y;
      3'd6: r = x & y;
      default: r = mask;
    endcase
    if (ar) begin
      r  = x + y + longint'(ci);
      co = ((r >> w) & 1) == 1;
      ov = (((x >> (w-1)) & 1) == ((y >> (w-1)) & 1)) &&
           (((r >> (w-1)) & 1) != ((x >> (w-1)) & 1));
    end
    fo = 16'(r & mask);
    zo = FLAGS && (fo == 0);
    no = FLAGS && (((r >> (w-1)) & 1) == 1);
    ov = FLAGS && ov;
  endfunction

  task automatic issue16(input logic [15:0] ai, input logic [15:0] bi,
                         input logic [2:0] si, input logic ci);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    a = ai; b = bi; s = si; cn = ci; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); s = 3'($urandom); cn = 1'($urandom);
  endtask

  // Called at the falling edge just after the accepting edge.
  task automatic await16(input string tag, input logic [15:0] ai, input logic [15:0] bi,
                         input logic [2:0] si, input logic ci);
    int lat;
    logic [15:0] ef;
    logic ec, eo, ez, en;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    model(16, ai, bi, si, ci, ef, ec, eo, ez, en);
    check({tag, "_latency"}, lat, 4);
    check({tag, "_f"}, f, ef);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_zero"}, zero, ez);
    check({tag, "_neg"}, neg, en);
    check({tag, "_ovf"}, ovf, eo);
  endtask

  task automatic retire16(input logic [15:0] ef);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("retire_out_valid", out_valid, 0);
    check("retire_f_hold", f, ef);
  endtask

  task automatic op16(input string tag, input logic [15:0] ai, input logic [15:0] bi,
                      input logic [2:0] si, input logic ci);
    logic [15:0] ef;
    logic ec, eo, ez, en;
    model(16, ai, bi, si, ci, ef, ec, eo, ez, en);
    issue16(ai, bi, si, ci);
    await16(tag, ai, bi, si, ci);
    retire16(ef);
  endtask

  task automatic op4(input string tag, input logic [3:0] ai, input logic [3:0] bi,
                     input logic [2:0] si, input logic ci);
    int lat;
    logic [15:0] ef;
    logic ec, eo, ez, en;
    model(4, {12'd0, ai}, {12'd0, bi}, si, ci, ef, ec, eo, ez, en);
    @(negedge clk);
    w4_a = ai; w4_b = bi; w4_s = si; w4_cn = ci; w4_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    w4_in_valid = 1'b0;
    w4_a = 4'($urandom); w4_b = 4'($urandom);
    lat = 0;
    while (!w4_out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "_latency"}, lat, 1);
    check({tag, "_f"}, w4_f, ef);
    check({tag, "_cout"}, w4_cout, ec);
    check({tag, "_zero"}, w4_zero, ez);
    check({tag, "_ovf"}, w4_ovf, eo);
    w4_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    w4_out_ready = 1'b0;
    check({tag, "_retired"}, w4_out_valid, 0);
  endtask

  initial begin
    logic [15:0] ra, rb, ef, ef2;
    logic [2:0]  rs;
    logic        rc, ec, eo, ez, en;

    rst_n = 1'b0;
    in_valid = 0; out_ready = 0; a = 0; b = 0; s = 0; cn = 0;
    w4_in_valid = 0; w4_out_ready = 0; w4_a = 0; w4_b = 0; w4_s = 0; w4_cn = 0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_f", f, 0);
    check("rst_cout", cout, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    // Directed vectors
    op16("add_ff", 16'h00FF, 16'h0001, 3'b011, 1'b0);
    op16("amb", 16'h0005, 16'h0007, 3'b010, 1'b1);
    op16("bma", 16'h0005, 16'h0007, 3'b001, 1'b1);
    op16("add_ovf", 16'h7FFF, 16'h0001, 3'b011, 1'b0);
    op16("ones", 16'h1234, 16'h5678, 3'b111, 1'b1);
    op16("zero_fn", 16'hFFFF, 16'hFFFF, 3'b000, 1'b1);

    // Stall with out_ready low, then retire and accept on the same edge
    model(16, 16'h1234, 16'h4321, 3'b011, 1'b1, ef, ec, eo, ez, en);
    issue16(16'h1234, 16'h4321, 3'b011, 1'b1);
    await16("stall_first", 16'h1234, 16'h4321, 3'b011, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_out_valid", out_valid, 1);
      check("stall_f", f, ef);
      check("stall_in_ready", in_ready, 0);
    end
    model(16, 16'hA5A5, 16'h0FF0, 3'b100, 1'b0, ef2, ec, eo, ez, en);
    a = 16'hA5A5; b = 16'h0FF0; s = 3'b100; cn = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 check("b2b_in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; s = 3'b111;
    check("b2b_retired", out_valid, 0);
    await16("b2b_second", 16'hA5A5, 16'h0FF0, 3'b100, 1'b0);
    retire16(ef2);

    // Reset in the middle of an add
    issue16(16'h00FF, 16'h0F01, 3'b011, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_f", f, 0);
    check("midrst_cout", cout, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    op16("after_rst", 16'h8000, 16'h8000, 3'b011, 1'b1);

    // Randomized vectors
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 3'($urandom); rc = 1'($urandom);
      if (i % 8 == 0) rb = ~ra;
      op16("rand", ra, rb, rs, rc);
    end

    // Single-slice instance
    op4("w4_ones", 4'h3, 4'h9, 3'b111, 1'b0);
    op4("w4_zero", 4'h3, 4'h9, 3'b000, 1'b1);
    op4("w4_add", 4'h7, 4'h1, 3'b011, 1'b0);
    for (int i = 0; i < 10; i++)
      op4("w4_rand", 4'($urandom), 4'($urandom), 3'($urandom), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
